// File: rtl/mmio_uart_pkg.sv
// Shared constants and state type for the memory-mapped UART transmitter.
// Optional parity support is selected with the MMIO_UART_TX_PARITY_EN macro.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTRL_TX_EN       = 0;
  localparam int CTRL_PARITY_ODD  = 1;

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } uart_state_t;
`endif

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level counter; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Bus-mapped UART 8N1 transmitter: register decode, TX FIFO and serializer FSM.
// Define MMIO_UART_TX_PARITY_EN to add a selectable even/odd parity bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h1001_0000,
  parameter int          FIFO_DEPTH       = 8,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_wren,
  input  logic        bus_rden,
  output logic [31:0] bus_rddata,
  output logic        uart_tx
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [1:0]    offset;
  logic          wr_hit;
  logic          push;
  logic          pop_req;
  logic          ovf_event;
  logic [7:0]    fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  logic [15:0]   baud_div;
  logic          tx_en;
  logic          parity_odd;
  logic          overflow;

  uart_state_t   state, state_d;
  logic [15:0]   cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [15:0]   div_q, div_d;
  logic [7:0]    data_q, data_d;
  logic          tx_bit;
  logic          last;
  logic          busy;

  logic          unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wrdata[31:16]};

  assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus_addr[3:2];
  assign wr_hit    = bus_wren && hit;
  assign push      = wr_hit && (offset == OFF_TXDATA);
  assign ovf_event = push && fifo_full && !pop_req;
  assign busy      = (state != S_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop_req),
    .wr_data (bus_wrdata[7:0]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // A new overflow event wins over a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div <= DEFAULT_BAUD_DIV;
      tx_en    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_hit && offset == OFF_BAUD)
        baud_div <= (bus_wrdata[15:0] == 16'd0) ? 16'd1 : bus_wrdata[15:0];
      if (wr_hit && offset == OFF_CTRL)
        tx_en <= bus_wrdata[CTRL_TX_EN];
      if (ovf_event)
        overflow <= 1'b1;
      else if (wr_hit && offset == OFF_STATUS && bus_wrdata[ST_OVERFLOW])
        overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)
      parity_odd <= 1'b0;
    else if (wr_hit && offset == OFF_CTRL)
      parity_odd <= bus_wrdata[CTRL_PARITY_ODD];
  end
`else
  assign parity_odd = 1'b0;
`endif

  always_comb begin
    bus_rddata = '0;
    if (bus_rden && hit) begin
      case (offset)
        OFF_STATUS: begin
          bus_rddata[ST_FULL]              = fifo_full;
          bus_rddata[ST_EMPTY]             = fifo_empty;
          bus_rddata[ST_BUSY]              = busy;
          bus_rddata[ST_OVERFLOW]          = overflow;
          bus_rddata[ST_LEVEL_LSB +: 8]    = 8'(fifo_level);
        end
        OFF_BAUD: bus_rddata[15:0] = baud_div;
        OFF_CTRL: begin
          bus_rddata[CTRL_TX_EN]      = tx_en;
          bus_rddata[CTRL_PARITY_ODD] = parity_odd;
        end
        default: bus_rddata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      div_q   <= DEFAULT_BAUD_DIV;
      data_q  <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      div_q   <= div_d;
      data_q  <= data_d;
    end
  end

  // Each symbol is held div_q cycles; the baud divisor is frozen at pop time.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    div_d   = div_q;
    data_d  = data_q;
    pop_req = 1'b0;
    tx_bit  = 1'b1;
    last    = (cnt == div_q - 16'd1);
    case (state)
      S_IDLE: begin
        if (!fifo_empty && tx_en) begin
          pop_req = 1'b1;
          data_d  = fifo_rd_data;
          div_d   = baud_div;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (last) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_DATA: begin
        tx_bit = data_q[bit_idx];
        if (last) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        tx_bit = parity_bit(data_q, parity_odd);
        if (last) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
`endif
      S_STOP: begin
        tx_bit = 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uart_tx = tx_bit;

endmodule
